mem_stage_rsp: RTL and testbench
================================

// Module: mem_stage_rsp
// PURPOSE
//  Memory stage for the 5-stage MIPS pipeline, successor to the fixed-latency MEM stage.
//  Sits between EXE and WB, behind a variable-latency SRAM-like data port (data_ok).
//  Holds each instruction until its data response arrives, buffers a response that WB
//  cannot yet accept, and extracts/merges LB/LBU/LH/LHU/LW/LWL/LWR data.
//  Flush support: responses still in flight for cancelled instructions are counted and dropped.
// PARAMETERS
//  REG_AW     5   register-file address width (dest field)
//  PC_W       32  PC width carried on the buses
//  DISCARD_W  2   width of the cancelled-response counter; max 2^DISCARD_W-1 pending drops
//  BUF_EN     1   1: response buffer present; 0: data_ok only accepted when ws_allowin=1
// PORTS
//  clk             in   1             clock
//  resetn          in   1             asynchronous reset, active low
//  ws_allowin      in   1             WB can accept
//  ms_allowin      out  1             MS can accept from EXE
//  es_to_ms_valid  in   1             EXE output valid
//  es_to_ms_bus    in   ES_TO_MS_BUS_WD  {ld_op[3],need_rsp,gr_we,dest,alu_result[32],rt_value[32],pc}
//  ms_to_ws_valid  out  1             MS output valid
//  ms_to_ws_bus    out  MS_TO_WS_BUS_WD  {gr_we,dest,final_result[32],pc}
//  data_sram_data_ok in 1             data response valid this cycle
//  data_sram_rdata in   32            response read data
//  ms_flush        in   1             cancel the instruction held in MS (exception/eret from WB)
//  ms_fwd_valid    out  1             MS holds a valid instruction writing a GPR
//  ms_fwd_ready    out  1             ms_result is final (0 while a load waits for data)
//  ms_dest         out  REG_AW        destination register
//  ms_result       out  32            forwarding value (= final_result)
// BEHAVIOUR
//  Reset (resetn=0, async): ms_valid=0, rsp_got=0, buf_valid=0, discard_cnt=0;
//   ms_to_ws_valid=0, ms_fwd_valid=0, ms_allowin=1. Bus register is not reset.
//  Accept: es_to_ms_valid && ms_allowin latches the bus; rsp_got/buf_valid are cleared the same edge.
//  need_rsp=1: the instruction issued a data request (load or store) and needs one data_ok.
//  Ownership of data_ok: if discard_cnt!=0, data_ok decrements it and is dropped.
//   Otherwise it belongs to the MS instruction.
//  ms_ready_go = !need_rsp | rsp_got | data_ok_owned. Zero extra latency when data_ok
//   arrives while ws_allowin=1.
//  Buffering: data_ok_owned && !ws_allowin -> rdata captured, buf_valid=1, rsp_got=1.
//   Hold until handoff. Mem data = buf_valid ? buf_data : data_sram_rdata.
//  BUF_EN=0: no buffer; rsp_got never set; behaviour is undefined if data_ok arrives with ws_allowin=0.
//  ms_allowin = !ms_valid | (ms_ready_go & ws_allowin). ms_to_ws_valid = ms_valid & ms_ready_go & !ms_flush.
//  Flush: ms_flush=1 clears ms_valid next edge.
//   If need_rsp && !rsp_got && !data_ok_owned that cycle, discard_cnt += 1.
//   Saturation is an assertion error.
//   A flush in the same cycle as an owned data_ok drops the data without counting.
//  ld_op: 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR, 7 none.
//   ld_op=7 gives final=alu_result; otherwise final=aligned load data.
//  Lane select uses a=alu_result[1:0], little-endian.
//   LB/LBU: byte a, sign- or zero-extended to 32.
//   LH/LHU: half a[1], sign- or zero-extended.
//   LWL: rdata<<(8*(3-a)) merged with the low 8*(3-a) bits of rt_value.
//   LWR: rdata>>(8*a) merged with the high 8*a bits of rt_value.
//   Misaligned LH/LW never reach MS (AdEL is raised in EXE).
//  ms_fwd_valid = ms_valid & gr_we. ms_fwd_ready = ld_op==7 | rsp_got | data_ok_owned.
//  Simultaneous: accept+flush does not occur (EXE is flushed too).
//   Drop-count decrement and flush increment in the same cycle leave the count net unchanged.
// STRUCTURE
//  mycpu.h: ES_TO_MS_BUS_WD=3+1+1+REG_AW+64+PC_W, MS_TO_WS_BUS_WD=1+REG_AW+32+PC_W,
//   LD_OP_* encodings, field-position macros.
//  Sub-module mem_load_align (combinational: ld_op, addr[1:0], rdata, rt_value -> result).
//  Main module contains valid/handshake, response buffer, discard counter.
// TESTING
//  1 LW, need_rsp=1, data_ok on the cycle after accept with ws_allowin=1 -> ms_to_ws_valid
//    that cycle, final=rdata; no stall on the ALU op that follows.
//  2 LB addr=...3, rdata=0x80FF1234 -> 0xFFFFFF80; LBU -> 0x00000080; LHU addr=..2 -> 0x000080FF.
//  3 LWL a=1, rdata=0xAABBCCDD, rt=0x11223344 -> 0xCCDD3344; LWR a=1 -> 0x11AABBCC.
//  4 data_ok with ws_allowin=0 for 3 cycles -> buf_valid=1, no second data_ok consumed,
//    handoff of buffered data when ws_allowin=1; ms_fwd_ready=1 throughout the wait.
//  5 Flush a load before data_ok, then accept an ALU op, then a new load:
//    first data_ok is dropped (discard 1->0), second data_ok completes the new load.
//  6 resetn pulled low mid-wait (buf_valid=1, discard_cnt=1) -> all state cleared immediately
//    (async); ms_allowin=1 and ms_to_ws_valid=0 before the next clk edge.

Source files
------------

// File: rtl/mem_stage_rsp_pkg.sv
// Shared types and bus-width helpers for the variable-latency memory stage.
package mem_stage_rsp_pkg;

  // Load extraction selector carried on the EXE->MS bus.
  typedef enum logic [2:0] {
    LD_LW   = 3'd0,
    LD_LB   = 3'd1,
    LD_LBU  = 3'd2,
    LD_LH   = 3'd3,
    LD_LHU  = 3'd4,
    LD_LWL  = 3'd5,
    LD_LWR  = 3'd6,
    LD_NONE = 3'd7
  } ld_op_e;

  // {ld_op[3], need_rsp, gr_we, dest, alu_result[32], rt_value[32], pc}
  function automatic int es_to_ms_bus_wd(input int reg_aw, input int pc_w);
    return 3 + 1 + 1 + reg_aw + 64 + pc_w;
  endfunction

  // {gr_we, dest, final_result[32], pc}
  function automatic int ms_to_ws_bus_wd(input int reg_aw, input int pc_w);
    return 1 + reg_aw + 32 + pc_w;
  endfunction

endpackage

// File: rtl/mem_stage_rsp_align.sv
// Combinational load data extraction / merge (little-endian byte lanes).
module mem_load_align
  import mem_stage_rsp_pkg::*;
(
  input  logic [2:0]  ld_op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  input  logic [31:0] rt_value,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] lwl_v;
  logic [31:0] lwr_v;

  // Select the addressed lane, build the unaligned merges, then pick by ld_op.
  always_comb begin
    byte_v = rdata[8*addr +: 8];
    half_v = addr[1] ? rdata[31:16] : rdata[15:0];
    case (addr)
      2'd0: begin
        lwl_v = {rdata[7:0], rt_value[23:0]};
        lwr_v = rdata;
      end
      2'd1: begin
        lwl_v = {rdata[15:0], rt_value[15:0]};
        lwr_v = {rt_value[31:24], rdata[31:8]};
      end
      2'd2: begin
        lwl_v = {rdata[23:0], rt_value[7:0]};
        lwr_v = {rt_value[31:16], rdata[31:16]};
      end
      default: begin
        lwl_v = rdata;
        lwr_v = {rt_value[31:8], rdata[31:24]};
      end
    endcase
    case (ld_op_e'(ld_op))
      LD_LB:   result = {{24{byte_v[7]}}, byte_v};
      LD_LBU:  result = {24'd0, byte_v};
      LD_LH:   result = {{16{half_v[15]}}, half_v};
      LD_LHU:  result = {16'd0, half_v};
      LD_LWL:  result = lwl_v;
      LD_LWR:  result = lwr_v;
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_rsp.sv
// MEM stage behind a variable-latency data port: holds the instruction until
// its data_ok, buffers a response WB cannot take yet, and drops responses that
// belong to flushed instructions.
//
// Handshake: a transfer happens on a clock edge where valid && ready/allowin are
// both high in the cycle before; valid never depends on the consumer's allowin,
// and the bus is stable while valid is held without a transfer.
module mem_stage_rsp
  import mem_stage_rsp_pkg::*;
#(
  parameter int REG_AW          = 5,
  parameter int PC_W            = 32,
  parameter int DISCARD_W       = 2,
  parameter bit BUF_EN          = 1'b1,
  parameter int ES_TO_MS_BUS_WD = es_to_ms_bus_wd(REG_AW, PC_W),
  parameter int MS_TO_WS_BUS_WD = ms_to_ws_bus_wd(REG_AW, PC_W)
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       ms_flush,
  output logic                       ms_fwd_valid,
  output logic                       ms_fwd_ready,
  output logic [REG_AW-1:0]          ms_dest,
  output logic [31:0]                ms_result
);

  localparam logic [DISCARD_W-1:0] DISC_MAX = '1;

  logic                       ms_valid_q, ms_valid_d;
  logic                       rsp_got_q, rsp_got_d;
  logic                       buf_valid_q, buf_valid_d;
  logic [31:0]                buf_data_q, buf_data_d;
  logic [DISCARD_W-1:0]       discard_cnt_q, discard_cnt_d;
  logic [ES_TO_MS_BUS_WD-1:0] bus_q, bus_d;

  logic [2:0]        ld_op;
  logic              need_rsp;
  logic              gr_we;
  logic [REG_AW-1:0] dest;
  logic [31:0]       alu_result;
  logic [31:0]       rt_value;
  logic [PC_W-1:0]   pc;

  logic        data_ok_owned;
  logic        ms_ready_go;
  logic        disc_inc;
  logic        disc_dec;
  logic [31:0] mem_data;
  logic [31:0] align_result;
  logic [31:0] final_result;

  assign {ld_op, need_rsp, gr_we, dest, alu_result, rt_value, pc} = bus_q;

  // A response is ours only once every cancelled request has been drained.
  assign data_ok_owned  = data_sram_data_ok && (discard_cnt_q == '0);
  assign disc_dec       = data_sram_data_ok && (discard_cnt_q != '0);
  assign disc_inc       = ms_flush && ms_valid_q && need_rsp && !rsp_got_q && !data_ok_owned;
  assign ms_ready_go    = !need_rsp || rsp_got_q || data_ok_owned;
  assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid_q && ms_ready_go && !ms_flush;

  assign mem_data     = buf_valid_q ? buf_data_q : data_sram_rdata;
  assign final_result = (ld_op == LD_NONE) ? alu_result : align_result;
  assign ms_to_ws_bus = {gr_we, dest, final_result, pc};
  assign ms_fwd_valid = ms_valid_q && gr_we;
  assign ms_fwd_ready = (ld_op == LD_NONE) || rsp_got_q || data_ok_owned;
  assign ms_dest      = dest;
  assign ms_result    = final_result;

  mem_load_align u_align (
    .ld_op    (ld_op),
    .addr     (alu_result[1:0]),
    .rdata    (mem_data),
    .rt_value (rt_value),
    .result   (align_result)
  );

  // Next-state: accept/handoff, response capture, flush and drop counting.
  always_comb begin
    ms_valid_d    = ms_valid_q;
    rsp_got_d     = rsp_got_q;
    buf_valid_d   = buf_valid_q;
    buf_data_d    = buf_data_q;
    discard_cnt_d = discard_cnt_q + DISCARD_W'(disc_inc) - DISCARD_W'(disc_dec);
    bus_d         = bus_q;
    if (ms_allowin) begin
      ms_valid_d  = es_to_ms_valid;
      rsp_got_d   = 1'b0;
      buf_valid_d = 1'b0;
      if (es_to_ms_valid) begin
        bus_d = es_to_ms_bus;
      end
    end else if (BUF_EN && ms_valid_q && need_rsp && !rsp_got_q && data_ok_owned) begin
      // WB is stalled: hold the read data so the port never has to repeat it.
      rsp_got_d   = 1'b1;
      buf_valid_d = 1'b1;
      buf_data_d  = data_sram_rdata;
    end
    if (ms_flush) begin
      ms_valid_d  = 1'b0;
      rsp_got_d   = 1'b0;
      buf_valid_d = 1'b0;
    end
  end

  // Control state with async reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid_q    <= 1'b0;
      rsp_got_q     <= 1'b0;
      buf_valid_q   <= 1'b0;
      discard_cnt_q <= '0;
    end else begin
      ms_valid_q    <= ms_valid_d;
      rsp_got_q     <= rsp_got_d;
      buf_valid_q   <= buf_valid_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

  // Datapath registers, deliberately without reset.
  always_ff @(posedge clk) begin
    bus_q      <= bus_d;
    buf_data_q <= buf_data_d;
  end

  // More outstanding cancelled responses than the counter can track.
  a_discard_no_overflow: assert property (
    @(posedge clk) disable iff (!resetn)
    !(disc_inc && !disc_dec && (discard_cnt_q == DISC_MAX))
  );

endmodule

// File: tb/tb_mem_stage_rsp.sv
// Directed bench for mem_stage_rsp: hand-computed load results, stall buffering,
// flush drop counting and asynchronous reset.
module tb_mem_stage_rsp;

  localparam int ES_WD = 106;
  localparam int MS_WD = 70;

  logic             clk;
  logic             resetn;
  logic             ws_allowin;
  logic             ms_allowin;
  logic             es_to_ms_valid;
  logic [ES_WD-1:0] es_to_ms_bus;
  logic             ms_to_ws_valid;
  logic [MS_WD-1:0] ms_to_ws_bus;
  logic             data_sram_data_ok;
  logic [31:0]      data_sram_rdata;
  logic             ms_flush;
  logic             ms_fwd_valid;
  logic             ms_fwd_ready;
  logic [4:0]       ms_dest;
  logic [31:0]      ms_result;

  int n_vec = 0;
  int n_err = 0;
  logic [MS_WD-1:0] exp_q[$];

  mem_stage_rsp dut (
    .clk               (clk),
    .resetn            (resetn),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ms_flush          (ms_flush),
    .ms_fwd_valid      (ms_fwd_valid),
    .ms_fwd_ready      (ms_fwd_ready),
    .ms_dest           (ms_dest),
    .ms_result         (ms_result)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [ES_WD-1:0] mk_in(input logic [2:0] op, input logic nr, input logic we,
                                             input logic [4:0] d, input logic [31:0] alu,
                                             input logic [31:0] rt, input logic [31:0] pc);
    return {op, nr, we, d, alu, rt, pc};
  endfunction

  function automatic logic [MS_WD-1:0] mk_out(input logic we, input logic [4:0] d,
                                              input logic [31:0] res, input logic [31:0] pc);
    return {we, d, res, pc};
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic accept_one(input logic [ES_WD-1:0] b);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = b;
    settle();
    chk("accept_allowin", ms_allowin, 1'b1);
    step();
    es_to_ms_valid = 1'b0;
  endtask

  task automatic load_rsp(input string tag, input logic [2:0] op, input logic [31:0] alu,
                          input logic [31:0] rt, input logic [31:0] rdata,
                          input logic [31:0] exp_res, input logic [31:0] pc);
    accept_one(mk_in(op, 1'b1, 1'b1, 5'd9, alu, rt, pc));
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rdata;
    exp_q.push_back(mk_out(1'b1, 5'd9, exp_res, pc));
    settle();
    chk(tag, ms_result, exp_res);
    step();
    data_sram_data_ok = 1'b0;
  endtask

  // scoreboard: every WB handoff must match the oldest expected bus
  always @(negedge clk) begin
    if (resetn && ms_to_ws_valid && ws_allowin) begin
      chk("handoff_pending", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) chk("handoff_bus", ms_to_ws_bus, exp_q.pop_front());
    end
  end

  initial begin
    resetn            = 1'b0;
    ws_allowin        = 1'b1;
    es_to_ms_valid    = 1'b0;
    es_to_ms_bus      = '0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    ms_flush          = 1'b0;
    #2;
    chk("rst_allowin", ms_allowin, 1'b1);
    chk("rst_to_ws_valid", ms_to_ws_valid, 1'b0);
    chk("rst_fwd_valid", ms_fwd_valid, 1'b0);
    step();
    step();
    resetn = 1'b1;

    // 1: LW with data_ok right after accept, ALU op follows without a stall
    accept_one(mk_in(3'd0, 1'b1, 1'b1, 5'd3, 32'h1000, 32'h0, 32'h100));
    es_to_ms_valid    = 1'b1;
    es_to_ms_bus      = mk_in(3'd7, 1'b0, 1'b1, 5'd4, 32'h55, 32'h0, 32'h104);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEADBEEF;
    exp_q.push_back(mk_out(1'b1, 5'd3, 32'hDEADBEEF, 32'h100));
    exp_q.push_back(mk_out(1'b1, 5'd4, 32'h55, 32'h104));
    settle();
    chk("lw_valid", ms_to_ws_valid, 1'b1);
    chk("lw_result", ms_result, 32'hDEADBEEF);
    chk("lw_fwd_ready", ms_fwd_ready, 1'b1);
    chk("lw_allowin", ms_allowin, 1'b1);
    step();
    es_to_ms_valid    = 1'b0;
    data_sram_data_ok = 1'b0;
    settle();
    chk("alu_valid", ms_to_ws_valid, 1'b1);
    chk("alu_result", ms_result, 32'h55);
    chk("alu_dest", ms_dest, 5'd4);
    step();
    settle();
    chk("idle_valid", ms_to_ws_valid, 1'b0);

    // 2/3: lane extraction and unaligned merges
    load_rsp("lb_a3",  3'd1, 32'h2003, 32'h0, 32'h80FF1234, 32'hFFFFFF80, 32'h110);
    load_rsp("lbu_a3", 3'd2, 32'h2003, 32'h0, 32'h80FF1234, 32'h00000080, 32'h114);
    load_rsp("lb_a0",  3'd1, 32'h2000, 32'h0, 32'h80FF1234, 32'h00000034, 32'h118);
    load_rsp("lhu_a2", 3'd4, 32'h2002, 32'h0, 32'h80FF1234, 32'h000080FF, 32'h11C);
    load_rsp("lh_a2",  3'd3, 32'h2002, 32'h0, 32'h80FF1234, 32'hFFFF80FF, 32'h120);
    load_rsp("lh_a0",  3'd3, 32'h2000, 32'h0, 32'h80FF1234, 32'h00001234, 32'h124);
    load_rsp("lwl_a1", 3'd5, 32'h2001, 32'h11223344, 32'hAABBCCDD, 32'hCCDD3344, 32'h128);
    load_rsp("lwr_a1", 3'd6, 32'h2001, 32'h11223344, 32'hAABBCCDD, 32'h11AABBCC, 32'h12C);
    load_rsp("lwl_a0", 3'd5, 32'h2000, 32'h11223344, 32'hAABBCCDD, 32'hDD223344, 32'h130);
    load_rsp("lwl_a3", 3'd5, 32'h2003, 32'h11223344, 32'hAABBCCDD, 32'hAABBCCDD, 32'h134);
    load_rsp("lwr_a0", 3'd6, 32'h2000, 32'h11223344, 32'hAABBCCDD, 32'hAABBCCDD, 32'h138);
    load_rsp("lwr_a3", 3'd6, 32'h2003, 32'h11223344, 32'hAABBCCDD, 32'h112233AA, 32'h13C);

    // 4: response arrives while WB stalls, held in the buffer
    accept_one(mk_in(3'd0, 1'b1, 1'b1, 5'd5, 32'h3000, 32'h0, 32'h200));
    ws_allowin        = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hCAFEF00D;
    settle();
    chk("buf_first_fwd_ready", ms_fwd_ready, 1'b1);
    chk("buf_first_allowin", ms_allowin, 1'b0);
    step();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("buf_hold_valid", ms_to_ws_valid, 1'b1);
      chk("buf_hold_fwd_ready", ms_fwd_ready, 1'b1);
      chk("buf_hold_result", ms_result, 32'hCAFEF00D);
      chk("buf_hold_allowin", ms_allowin, 1'b0);
      step();
    end
    ws_allowin = 1'b1;
    exp_q.push_back(mk_out(1'b1, 5'd5, 32'hCAFEF00D, 32'h200));
    settle();
    chk("buf_release_allowin", ms_allowin, 1'b1);
    step();
    settle();
    chk("buf_after_valid", ms_to_ws_valid, 1'b0);

    // 5: flushed load's response is dropped, the next load takes the second one
    accept_one(mk_in(3'd0, 1'b1, 1'b1, 5'd6, 32'h4000, 32'h0, 32'h300));
    ms_flush = 1'b1;
    settle();
    chk("flush_valid", ms_to_ws_valid, 1'b0);
    step();
    ms_flush       = 1'b0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_in(3'd7, 1'b0, 1'b1, 5'd6, 32'h77, 32'h0, 32'h304);
    exp_q.push_back(mk_out(1'b1, 5'd6, 32'h77, 32'h304));
    settle();
    chk("flush_allowin", ms_allowin, 1'b1);
    step();
    es_to_ms_bus = mk_in(3'd0, 1'b1, 1'b1, 5'd7, 32'h2000, 32'h0, 32'h308);
    settle();
    chk("flush_alu_valid", ms_to_ws_valid, 1'b1);
    step();
    es_to_ms_valid    = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h11111111;
    settle();
    chk("drop_valid", ms_to_ws_valid, 1'b0);
    chk("drop_fwd_ready", ms_fwd_ready, 1'b0);
    step();
    data_sram_rdata = 32'h22222222;
    exp_q.push_back(mk_out(1'b1, 5'd7, 32'h22222222, 32'h308));
    settle();
    chk("owned_valid", ms_to_ws_valid, 1'b1);
    chk("owned_result", ms_result, 32'h22222222);
    step();
    data_sram_data_ok = 1'b0;

    // 6a: async reset while a load waits and one drop is pending
    accept_one(mk_in(3'd0, 1'b1, 1'b1, 5'd8, 32'h5000, 32'h0, 32'h400));
    ms_flush = 1'b1;
    step();
    ms_flush = 1'b0;
    accept_one(mk_in(3'd0, 1'b1, 1'b1, 5'd8, 32'h5000, 32'h0, 32'h404));
    ws_allowin = 1'b0;
    settle();
    chk("pre_rst_fwd_ready", ms_fwd_ready, 1'b0);
    #1 resetn = 1'b0;
    #1;
    chk("arst_allowin", ms_allowin, 1'b1);
    chk("arst_valid", ms_to_ws_valid, 1'b0);
    chk("arst_fwd_valid", ms_fwd_valid, 1'b0);
    step();
    step();
    resetn     = 1'b1;
    ws_allowin = 1'b1;
    load_rsp("post_rst_disc_clear", 3'd0, 32'h5000, 32'h0, 32'h33333333, 32'h33333333, 32'h408);

    // 6b: async reset with the response buffer full
    accept_one(mk_in(3'd0, 1'b1, 1'b1, 5'd8, 32'h6000, 32'h0, 32'h40C));
    ws_allowin        = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h44444444;
    step();
    data_sram_data_ok = 1'b0;
    settle();
    chk("pre_rst_buf_valid", ms_to_ws_valid, 1'b1);
    #1 resetn = 1'b0;
    #1;
    chk("arst_buf_allowin", ms_allowin, 1'b1);
    chk("arst_buf_valid", ms_to_ws_valid, 1'b0);
    step();
    step();
    resetn     = 1'b1;
    ws_allowin = 1'b1;
    load_rsp("post_rst_buf_clear", 3'd0, 32'h6000, 32'h0, 32'h55555555, 32'h55555555, 32'h410);

    step();
    chk("exp_q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
